dllp_receive: RTL and testbench

Parses the Data Link Layer Packets (DLLPs) received from the PHY and drives the Ack/Nak and flow-control inputs of `dllp_transmit`. It accepts one AXI-Stream slave carrying 6-byte DLLPs and checks each DLLP's CRC-16. It decodes Ack, Nak, InitFC1/2 and UpdateFC for VC0 and emits one-cycle event pulses plus held credit values. It sits directly upstream of `dllp_transmit` on the ack/nack and tx_fc ports.

---
 rtl/dllp_receive_if.sv | 16 +
 rtl/dllp_receive.sv | 162 ++++++++++++++++
 tb/tb_dllp_receive.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dllp_receive_if.sv
// AXI-Stream bundle carrying 6-byte DLLPs from the PHY into dllp_receive.
interface dllp_receive_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/dllp_receive.sv
// DLLP receiver: CRC-16 check, Ack/Nak and VC0 flow-control decode; outputs register 1 cycle
// after the CRC beat; tready is held high whenever out of reset, so there is no backpressure.
module dllp_receive #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dllp_receive_if.slave s_axis,
  output logic          ack_nack_o,
  output logic          ack_nack_vld_o,
  output logic [11:0]   ack_seq_num_o,
  output logic [7:0]    tx_fc_ph_o,
  output logic [11:0]   tx_fc_pd_o,
  output logic [7:0]    tx_fc_nph_o,
  output logic [11:0]   tx_fc_npd_o,
  output logic [7:0]    tx_fc_cplh_o,
  output logic [11:0]   tx_fc_cpld_o,
  output logic          update_fc_o,
  output logic [2:0]    fc_init_o,
  output logic          crc_err_o,
  output logic          frame_err_o
);

  if (DATA_WIDTH != 32 || KEEP_WIDTH != DATA_WIDTH / 8 || USER_WIDTH < 1) begin : g_bad_width
    $error("dllp_receive: only DATA_WIDTH=32 is supported");
  end

  typedef struct packed {
    logic [7:0] b3;
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } hdr_t;

  typedef enum logic [1:0] {
    B0   = 2'd0,
    B1   = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  hdr_t        hdr_q;
  logic [15:0] crc_exp;
  logic [7:0]  hdr_fc;
  logic [11:0] data_fc;
  logic        beat;
  logic        unused_bits;

  // Bytes enter LSB first; the remainder is complemented and bit-reversed per byte.
  // Result is in wire order {byte5, byte4}.
  function automatic logic [15:0] dllp_crc(input hdr_t h);
    logic [31:0] bits;
    logic [15:0] c;
    logic [15:0] res;
    logic        fb;
    bits = h;
    c    = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    for (int i = 0; i < 8; i++) begin
      res[i]     = ~c[15-i];
      res[8 + i] = ~c[7-i];
    end
    return res;
  endfunction

  assign s_axis.tready = ~rst_i;
  assign beat          = s_axis.tvalid & s_axis.tready;
  assign crc_exp       = dllp_crc(hdr_q);
  assign hdr_fc        = {hdr_q.b1[5:0], hdr_q.b2[7:6]};
  assign data_fc       = {hdr_q.b2[3:0], hdr_q.b3};
  assign unused_bits   = &{1'b0, hdr_q.b1[7:6], hdr_q.b2[5:4], s_axis.tuser};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= B0;
      hdr_q          <= '0;
      ack_nack_o     <= 1'b0;
      ack_nack_vld_o <= 1'b0;
      ack_seq_num_o  <= '0;
      tx_fc_ph_o     <= '0;
      tx_fc_pd_o     <= '0;
      tx_fc_nph_o    <= '0;
      tx_fc_npd_o    <= '0;
      tx_fc_cplh_o   <= '0;
      tx_fc_cpld_o   <= '0;
      update_fc_o    <= 1'b0;
      fc_init_o      <= '0;
      crc_err_o      <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      ack_nack_vld_o <= 1'b0;
      update_fc_o    <= 1'b0;
      crc_err_o      <= 1'b0;
      frame_err_o    <= 1'b0;
      if (beat) begin
        unique case (state)
          B0: begin
            if (s_axis.tlast || s_axis.tkeep != 4'hF) begin
              frame_err_o <= 1'b1;
            end else begin
              hdr_q <= s_axis.tdata;
              state <= B1;
            end
          end
          B1: begin
            if (!s_axis.tlast) begin
              frame_err_o <= 1'b1;
              state       <= DROP;
            end else begin
              state <= B0;
              if (s_axis.tkeep != 4'h3) begin
                frame_err_o <= 1'b1;
              end else if (s_axis.tdata[15:0] != crc_exp) begin
                crc_err_o <= 1'b1;
              end else begin
                // Byte 0 bit 6 distinguishes InitFC1/InitFC2 from UpdateFC.
                unique case (hdr_q.b0)
                  8'h00, 8'h10: begin
                    ack_nack_o     <= (hdr_q.b0 == 8'h00);
                    ack_seq_num_o  <= data_fc;
                    ack_nack_vld_o <= 1'b1;
                  end
                  8'h40, 8'hC0, 8'h80: begin
                    tx_fc_ph_o   <= hdr_fc;
                    tx_fc_pd_o   <= data_fc;
                    update_fc_o  <= 1'b1;
                    fc_init_o[0] <= fc_init_o[0] | hdr_q.b0[6];
                  end
                  8'h50, 8'hD0, 8'h90: begin
                    tx_fc_nph_o  <= hdr_fc;
                    tx_fc_npd_o  <= data_fc;
                    update_fc_o  <= 1'b1;
                    fc_init_o[1] <= fc_init_o[1] | hdr_q.b0[6];
                  end
                  8'h60, 8'hE0, 8'hA0: begin
                    tx_fc_cplh_o <= hdr_fc;
                    tx_fc_cpld_o <= data_fc;
                    update_fc_o  <= 1'b1;
                    fc_init_o[2] <= fc_init_o[2] | hdr_q.b0[6];
                  end
                  default: ;
                endcase
              end
            end
          end
          DROP: begin
            if (s_axis.tlast) begin
              state <= B0;
            end
          end
          default: state <= B0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dllp_receive.sv
// Randomized bench for dllp_receive, every output compared each cycle against a DLLP-level model.
module tb_dllp_receive;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dllp_receive_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) axis ();

  logic        ack_nack;
  logic        ack_nack_vld;
  logic [11:0] ack_seq;
  logic [7:0]  fc_ph;
  logic [11:0] fc_pd;
  logic [7:0]  fc_nph;
  logic [11:0] fc_npd;
  logic [7:0]  fc_cplh;
  logic [11:0] fc_cpld;
  logic        update_fc;
  logic [2:0]  fc_init;
  logic        crc_err;
  logic        frame_err;

  dllp_receive #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_axis         (axis),
    .ack_nack_o     (ack_nack),
    .ack_nack_vld_o (ack_nack_vld),
    .ack_seq_num_o  (ack_seq),
    .tx_fc_ph_o     (fc_ph),
    .tx_fc_pd_o     (fc_pd),
    .tx_fc_nph_o    (fc_nph),
    .tx_fc_npd_o    (fc_npd),
    .tx_fc_cplh_o   (fc_cplh),
    .tx_fc_cpld_o   (fc_cpld),
    .update_fc_o    (update_fc),
    .fc_init_o      (fc_init),
    .crc_err_o      (crc_err),
    .frame_err_o    (frame_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: what the outputs must show after the most recent clock edge.
  int         m_pos;
  logic [7:0] m_b [4];
  bit         m_ack;
  int         m_seq;
  int         m_hdr [3];
  int         m_dat [3];
  int         m_init;
  bit         m_vld, m_upd, m_crc, m_frm;

  logic [7:0] dllp_types [12] = '{8'h00, 8'h10, 8'h40, 8'h50, 8'h60, 8'hC0,
                                  8'hD0, 8'hE0, 8'h80, 8'h90, 8'hA0, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reflected (right-shifting) form of the DLLP CRC; returns wire order {byte5, byte4}.
  function automatic logic [15:0] ref_crc(input logic [7:0] b0, b1, b2, b3);
    logic [15:0] r;
    logic [7:0]  bs [4];
    bs = '{b0, b1, b2, b3};
    r  = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      r = r ^ {8'h00, bs[k]};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 16'hD008) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic model_eval(input logic [15:0] crc_rx);
    int t, dat, hdr, kind, typ;
    if (crc_rx != ref_crc(m_b[0], m_b[1], m_b[2], m_b[3])) begin
      m_crc = 1'b1;
      return;
    end
    t   = int'(m_b[0]);
    dat = (int'(m_b[2]) % 16) * 256 + int'(m_b[3]);
    hdr = (int'(m_b[1]) % 64) * 4 + int'(m_b[2]) / 64;
    if (t == 'h00 || t == 'h10) begin
      m_vld = 1'b1;
      m_ack = (t == 'h00);
      m_seq = dat;
    end else if (t % 16 == 0) begin
      kind = t / 64;        // 1 InitFC1, 2 UpdateFC, 3 InitFC2
      typ  = (t / 16) % 4;  // 0 P, 1 NP, 2 Cpl
      if (kind != 0 && typ != 3) begin
        m_hdr[typ] = hdr;
        m_dat[typ] = dat;
        m_upd      = 1'b1;
        if (kind != 2) m_init = m_init | (1 << typ);
      end
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    m_vld = 1'b0; m_upd = 1'b0; m_crc = 1'b0; m_frm = 1'b0;
    if (r) begin
      m_pos = 0; m_ack = 1'b0; m_seq = 0; m_init = 0;
      for (int i = 0; i < 3; i++) begin m_hdr[i] = 0; m_dat[i] = 0; end
      return;
    end
    if (!v) return;
    if (m_pos == 0) begin
      if (l || k != 4'hF) m_frm = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) m_b[i] = d[8*i +: 8];
        m_pos = 1;
      end
    end else if (m_pos == 1) begin
      if (!l) begin
        m_frm = 1'b1;
        m_pos = 2;
      end else begin
        m_pos = 0;
        if (k != 4'h3) m_frm = 1'b1;
        else model_eval(d[15:0]);
      end
    end else if (l) begin
      m_pos = 0;
    end
  endtask

  task automatic compare_all();
    check("tready",       32'(axis.tready),  32'(!rst));
    check("ack_nack",     32'(ack_nack),     32'(m_ack));
    check("ack_nack_vld", 32'(ack_nack_vld), 32'(m_vld));
    check("ack_seq",      32'(ack_seq),      32'(m_seq));
    check("fc_ph",        32'(fc_ph),        32'(m_hdr[0]));
    check("fc_pd",        32'(fc_pd),        32'(m_dat[0]));
    check("fc_nph",       32'(fc_nph),       32'(m_hdr[1]));
    check("fc_npd",       32'(fc_npd),       32'(m_dat[1]));
    check("fc_cplh",      32'(fc_cplh),      32'(m_hdr[2]));
    check("fc_cpld",      32'(fc_cpld),      32'(m_dat[2]));
    check("update_fc",    32'(update_fc),    32'(m_upd));
    check("fc_init",      32'(fc_init),      32'(m_init));
    check("crc_err",      32'(crc_err),      32'(m_crc));
    check("frame_err",    32'(frame_err),    32'(m_frm));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic l);
    rst         = r;
    axis.tvalid = v;
    axis.tdata  = d;
    axis.tkeep  = k;
    axis.tlast  = l;
    axis.tuser  = 1'($urandom());
    model_step(r, v, d, k, l);
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, $urandom(), 4'($urandom()), 1'($urandom()));
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic l);
    tick();
    drive(r, v, d, k, l);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      drive_idle();
    end
  endtask

  task automatic send(input logic [7:0] b0, b1, b2, b3, input logic [15:0] crc_xor, input int gap);
    cycle(1'b0, 1'b1, {b3, b2, b1, b0}, 4'hF, 1'b0);
    idle(gap);
    cycle(1'b0, 1'b1, {16'h0000, ref_crc(b0, b1, b2, b3) ^ crc_xor}, 4'h3, 1'b1);
  endtask

  initial begin
    int sel, n, gap;
    logic [7:0] t0;

    rst = 1'b1; axis.tvalid = 1'b0; axis.tdata = '0; axis.tkeep = '0;
    axis.tlast = 1'b0; axis.tuser = '0;
    model_step(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    check("rst_tready", 32'(axis.tready), 32'h0);
    check("rst_fc_cpld", 32'(fc_cpld), 32'h0);
    drive_idle();

    send(8'h00, 8'h00, 8'h01, 8'h23, 16'h0000, 0);
    tick();
    check("ack123_vld", 32'(ack_nack_vld), 32'h1);
    check("ack123_type", 32'(ack_nack), 32'h1);
    check("ack123_seq", 32'(ack_seq), 32'h123);
    drive_idle();

    send(8'h90, 8'h0A, 8'h83, 8'hC5, 16'h0000, 1);
    tick();
    check("updnp_hdr", 32'(fc_nph), 32'h2A);
    check("updnp_dat", 32'(fc_npd), 32'h3C5);
    check("updnp_pulse", 32'(update_fc), 32'h1);
    check("updnp_init", 32'(fc_init), 32'h0);
    drive_idle();

    send(8'h40, 8'h01, 8'h40, 8'h10, 16'h0000, 0);
    send(8'h50, 8'h02, 8'h80, 8'h20, 16'h0000, 0);
    send(8'h60, 8'h03, 8'hC0, 8'h30, 16'h0000, 0);
    tick();
    check("initfc_all", 32'(fc_init), 32'h7);
    check("initfc_cplh", 32'(fc_cplh), 32'h0F);
    drive_idle();

    send(8'h10, 8'h00, 8'h0F, 8'hFF, 16'h00FF, 0);
    tick();
    check("nak_crc_err", 32'(crc_err), 32'h1);
    check("nak_no_vld", 32'(ack_nack_vld), 32'h0);
    check("nak_seq_held", 32'(ack_seq), 32'h123);
    drive_idle();

    cycle(1'b0, 1'b1, 32'h0400_0000, 4'hF, 1'b1);
    tick();
    check("onebeat_ferr", 32'(frame_err), 32'h1);
    drive_idle();
    send(8'h00, 8'h00, 8'h04, 8'h56, 16'h0000, 0);
    tick();
    check("ack456_seq", 32'(ack_seq), 32'h456);
    drive_idle();

    cycle(1'b0, 1'b1, $urandom(), 4'hF, 1'b0);
    cycle(1'b0, 1'b1, $urandom(), 4'hF, 1'b0);
    tick();
    check("burst_ferr", 32'(frame_err), 32'h1);
    drive(1'b0, 1'b1, $urandom(), 4'hF, 1'b0);
    tick();
    check("burst_drop_quiet", 32'(frame_err), 32'h0);
    drive(1'b0, 1'b1, $urandom(), 4'h3, 1'b1);
    send(8'h00, 8'h00, 8'h07, 8'h89, 16'h0000, 0);
    tick();
    check("ack789_seq", 32'(ack_seq), 32'h789);
    check("ack789_vld", 32'(ack_nack_vld), 32'h1);
    drive_idle();

    cycle(1'b0, 1'b1, 32'h5543_0280, 4'hF, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    check("rst_mid_init", 32'(fc_init), 32'h0);
    check("rst_mid_seq", 32'(ack_seq), 32'h0);
    check("rst_mid_nph", 32'(fc_nph), 32'h0);
    drive_idle();
    send(8'h80, 8'h02, 8'h43, 8'h55, 16'h0000, 0);
    tick();
    check("post_rst_ph", 32'(fc_ph), 32'h09);
    check("post_rst_pd", 32'(fc_pd), 32'h355);
    drive_idle();

    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 19);
      case (sel)
        0: cycle(1'b0, 1'b1, $urandom(), 4'hF, 1'b1);
        1: begin
          n = $urandom_range(3, 5);
          cycle(1'b0, 1'b1, $urandom(), 4'hF, 1'b0);
          for (int i = 1; i < n; i++) cycle(1'b0, 1'b1, $urandom(), 4'($urandom()), 1'(i == n - 1));
        end
        2: repeat ($urandom_range(1, 2)) cycle(1'b1, 1'($urandom()), $urandom(), 4'($urandom()), 1'($urandom()));
        3: cycle(1'b0, 1'b1, $urandom(), 4'h7, 1'b0);
        4: begin
          cycle(1'b0, 1'b1, $urandom(), 4'hF, 1'b0);
          cycle(1'b0, 1'b1, $urandom(), 4'hF, 1'b1);
        end
        default: begin
          n  = $urandom_range(0, 11);
          t0 = (n == 11) ? 8'($urandom()) : dllp_types[n];
          gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
          send(t0, 8'($urandom()), 8'($urandom()), 8'($urandom()),
               ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000, gap);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(2);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
